sync_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that sequences a dual-port RAM (one write port, one asynchronous read port) as a first-word-fall-through queue. It owns the write/read pointers, generates the RAM write strobe and addresses, and presents valid/ready handshakes on both sides with full/empty, almost-full/almost-empty and occupancy outputs. It sits between a producer and a consumer in the same clock domain and instantiates no storage itself.

---
 rtl/sync_fifo_ctrl.sv | 102 ++++++++++
 tb/tb_sync_fifo_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock first-word-fall-through FIFO controller.
// Drives an external dual-port RAM (registered write, asynchronous read).
// It owns the pointers, occupancy count, handshakes and status flags.
module sync_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 2**ADDR_WIDTH,
    parameter int unsigned AFULL_TH   = DEPTH - 2,
    parameter int unsigned AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int unsigned PtrW = ADDR_WIDTH + 1;
    localparam logic [PtrW-1:0] AfullTh  = PtrW'(AFULL_TH);
    localparam logic [PtrW-1:0] AemptyTh = PtrW'(AEMPTY_TH);

    // Pointer wrap-bit scheme only distinguishes full/empty for a power-of-two depth.
    if (DEPTH != 2**ADDR_WIDTH) begin : g_depth_check
        $error("sync_fifo_ctrl: DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] count_q, count_d;
    logic            wr_fire, rd_fire;

    // Status flags and handshakes come only from registered state.
    always_comb begin
        empty        = (wr_ptr_q == rd_ptr_q);
        full         = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                       (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
        almost_full  = (count_q >= AfullTh);
        almost_empty = (count_q <= AemptyTh);
        wr_ready     = ~full;
        rd_valid     = ~empty;
        count        = count_q;
    end

    // Handshake fires and RAM port drive; no write during reset or flush.
    always_comb begin
        wr_fire     = wr_valid & wr_ready;
        rd_fire     = rd_valid & rd_ready;
        ram_wr_en   = wr_fire & rst_n & ~flush;
        ram_wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
        ram_wr_data = wr_data;
        ram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
        rd_data     = ram_rd_data;
    end

    // Next pointer/count state; flush discards any concurrent transfer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({wr_fire, rd_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed stimulus against a queue-based reference model,
// with a small RAM attached to the controller's RAM ports.
module tb_sync_fifo_ctrl;

    localparam int DW        = 16;
    localparam int AW        = 4;
    localparam int DEPTH     = 16;
    localparam int AFULL_TH  = 14;
    localparam int AEMPTY_TH = 2;

    logic          clk = 1'b0;
    logic          rst_n, flush, wr_valid, rd_ready;
    logic          wr_ready, rd_valid, ram_wr_en;
    logic [DW-1:0] wr_data, rd_data, ram_wr_data, ram_rd_data;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [AW:0]   count;
    logic          full, empty, almost_full, almost_empty;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty)
    );

    // Attached RAM: clocked write, asynchronous read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    assign ram_rd_data = mem[ram_rd_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of stored words plus total write/read counts.
    logic [DW-1:0] q[$];
    int            wr_tot = 0;
    int            rd_tot = 0;
    bit            model_ok = 0;

    initial begin
        forever begin
            bit w, r;
            @(negedge clk);
            if (model_ok) begin
                chk("count", count, q.size());
                chk("empty", empty, q.size() == 0);
                chk("full", full, q.size() == DEPTH);
                chk("almost_full", almost_full, q.size() >= AFULL_TH);
                chk("almost_empty", almost_empty, q.size() <= AEMPTY_TH);
                chk("wr_ready", wr_ready, q.size() < DEPTH);
                chk("rd_valid", rd_valid, q.size() > 0);
                chk("ram_wr_en", ram_wr_en,
                    rst_n && !flush && wr_valid && (q.size() < DEPTH));
                chk("ram_wr_addr", ram_wr_addr, wr_tot % DEPTH);
                chk("ram_rd_addr", ram_rd_addr, rd_tot % DEPTH);
                if (q.size() > 0) chk("rd_data", rd_data, q[0]);
            end
            // Advance the model to the state after the coming rising edge.
            if (!rst_n) begin
                q.delete();
                wr_tot   = 0;
                rd_tot   = 0;
                model_ok = 1;
            end else if (model_ok) begin
                if (flush) begin
                    q.delete();
                    wr_tot = 0;
                    rd_tot = 0;
                end else begin
                    w = wr_valid && (q.size() < DEPTH);
                    r = rd_ready && (q.size() > 0);
                    if (r) begin
                        void'(q.pop_front());
                        rd_tot++;
                    end
                    if (w) begin
                        q.push_back(wr_data);
                        wr_tot++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 16'h1234;
        rd_ready = 1'b0;
        repeat (2) step();
        chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_wr_ready", wr_ready, 1);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_ram_wr_en", ram_wr_en, 0);
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        step();

        // Fill to full, then a held 17th write.
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'(i);
            step();
        end
        chk("fill_count", count, 16);
        chk("fill_full", full, 1);
        wr_data = 16'hDEAD;
        #1;
        chk("held_ram_wr_en", ram_wr_en, 0);
        chk("held_wr_ready", wr_ready, 0);
        step();
        chk("held_count", count, 16);
        wr_valid = 1'b0;

        // Drain in order.
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", rd_data, i);
            step();
        end
        chk("drain_empty", empty, 1);
        rd_ready = 1'b0;

        // Refill, then simultaneous write+read at full.
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'(16'h0100 + i);
            step();
        end
        wr_data  = 16'hBEEF;
        rd_ready = 1'b1;
        #1;
        chk("full_both_wr_en", ram_wr_en, 0);
        step();
        chk("full_both_count", count, 15);
        chk("full_both_wr_ready", wr_ready, 1);
        chk("full_both_head", rd_data, 16'h0101);
        wr_valid = 1'b0;
        repeat (15) step();
        chk("redrain_empty", empty, 1);

        // Simultaneous write+read at empty: write only.
        wr_valid = 1'b1;
        wr_data  = 16'h0C0C;
        step();
        chk("empty_both_count", count, 1);
        chk("empty_both_head", rd_data, 16'h0C0C);

        // Streaming across pointer wrap: occupancy stays at one.
        for (int i = 0; i < 40; i++) begin
            wr_data = 16'(16'h2000 + i);
            step();
            chk("stream_count", count, 1);
            chk("stream_head", rd_data, 16'h2000 + i);
        end
        wr_valid = 1'b0;
        step();
        rd_ready = 1'b0;

        // Flush with concurrent write and read.
        for (int i = 0; i < 7; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'(16'h0300 + i);
            step();
        end
        wr_valid = 1'b0;
        chk("preflush_count", count, 7);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 16'hFFFF;
        rd_ready = 1'b1;
        #1;
        chk("flush_ram_wr_en", ram_wr_en, 0);
        step();
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        wr_valid = 1'b1;
        wr_data  = 16'hA5A5;
        step();
        wr_valid = 1'b0;
        chk("postflush_valid", rd_valid, 1);
        chk("postflush_data", rd_data, 16'hA5A5);

        // Reset mid-operation discards contents.
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'(16'h0400 + i);
            step();
        end
        wr_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midreset_count", count, 0);
        chk("midreset_empty", empty, 1);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
